lab7_soc_leds_pio: RTL and testbench
====================================

// Module: lab7_soc_leds_pio
// PURPOSE
//  Avalon-MM slave output PIO: the write-side counterpart of the switches input PIO.
//  Holds a CPU-written output register that drives board LEDs, with atomic set/clear and a
//  self-timed inversion pulse (blink) so firmware can flash bits without polling.
//  Sits in lab7_soc between the Nios II data master interconnect and the LED pins.
// PARAMETERS
//  WIDTH        8      output port width, 1..32
//  RESET_VALUE  0      DATA register and out_port value in and after reset (WIDTH bits)
//  PLEN_W       16     width of pulse-length register and down-counter
//  PLEN_RESET   1000   PULSE_LEN value after reset
// PORTS
//  clk         in   1      system clock; single clock domain
//  reset_n     in   1      asynchronous, active-low reset
//  address     in   3      word address, Avalon s1
//  chipselect  in   1      slave select; writes ignored when 0
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data; bits above WIDTH (or PLEN_W) ignored
//  readdata    out  32     registered read data, zero-extended
//  out_port    out  WIDTH  LED drive = DATA ^ PULSE_ACTIVE
// BEHAVIOUR
//  Register map (addr: name, access):
//   0 DATA rw | 1 PULSE rw(r = active mask) | 2 PULSE_LEN rw | 3 COUNT r | 4 OUTSET w | 5 OUTCLEAR w
//   6,7 reserved: read 0, writes ignored; w-only addrs 4,5 read 0.
//  Write accepted when chipselect=1 && write_n=0; takes effect at that clk edge; no waitrequest.
//  Reset (async assert, sync-to-clk release is upstream's job): DATA=RESET_VALUE,
//   PULSE_ACTIVE=0, count=0, PULSE_LEN=PLEN_RESET, readdata=0, out_port=RESET_VALUE.
//  Read: readdata <= zero_extend(mux(address)) every cycle regardless of chipselect;
//   read latency exactly 1 cycle; readdata reflects register state before the same-edge write.
//  OUTSET: DATA <= DATA | wd; OUTCLEAR: DATA <= DATA & ~wd (single cycle, atomic).
//  Pulse state machine (IDLE / ACTIVE):
//   IDLE: PULSE_ACTIVE=0. Write PULSE with wd[WIDTH-1:0]!=0 -> ACTIVE, mask<=wd,
//    count <= (PULSE_LEN==0) ? 1 : PULSE_LEN. Write of 0 -> stays IDLE.
//   ACTIVE: count decrements by 1 per cycle; when count==1 at an edge -> IDLE, mask<=0, count<=0.
//    Pulse visible on out_port for exactly max(PULSE_LEN,1) cycles.
//   Write PULSE while ACTIVE: nonzero wd restarts (mask replaced, count reloaded); wd==0
//    aborts immediately -> IDLE. Restart wins over same-edge expiry.
//  Write PULSE_LEN during ACTIVE affects only the next start; in-flight count unchanged.
//  DATA/OUTSET/OUTCLEAR writes during ACTIVE update DATA; pulse continues, out_port = new DATA ^ mask.
//  COUNT reads the live down-counter (0 in IDLE).
//  out_port is combinational from DATA and mask registers only (glitch-free, no input path).
//  Reset mid-pulse: pulse cancelled, outputs to reset values asynchronously.
// STRUCTURE
//  Package lab7_pio_pkg: address localparams (ADDR_DATA..ADDR_OUTCLEAR), pulse state enum
//   {P_IDLE, P_ACTIVE}; shared by future PIO variants.
//  One sub-module: lab7_pio_pulse_timer (start/load/abort in, count + active out, param PLEN_W);
//   top holds register file, write decode, read mux and out_port XOR.
// TESTING
//  Reset: hold reset_n=0 -> out_port=RESET_VALUE, readdata=0, read addr2 = 1000.
//  Write DATA=0xA5, read addr0 -> readdata=0x000000A5 one cycle after address; out_port=0xA5.
//  DATA=0xA5; OUTSET 0x0F -> 0xAF; OUTCLEAR 0xA0 -> 0x0F; chipselect=0 write ignored.
//  PULSE_LEN=3, PULSE=0x01 -> out_port=0x0E for exactly 3 cycles then 0x0F; COUNT reads 3,2,1,0.
//  PULSE_LEN=0, PULSE=0x80 -> 1-cycle pulse; PULSE=0x02 mid-pulse (len 5) restarts 5 cycles; PULSE=0 aborts.
//  Assert reset_n mid-pulse (count=2) -> out_port=RESET_VALUE same cycle, COUNT reads 0 after release.

Source files
------------

// File: rtl/lab7_pio_pkg.sv
// Shared definitions for the lab7 PIO family: register addresses and pulse states.
package lab7_pio_pkg;

   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned BUS_W    = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_PULSE    = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_PLEN     = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_COUNT    = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

   typedef enum logic [0:0] {
      P_IDLE   = 1'b0,
      P_ACTIVE = 1'b1
   } pulse_state_t;

endpackage

// File: rtl/lab7_pio_pulse_timer.sv
// Self-timed pulse down-counter: start/restart loads the length, abort or count==1 ends it.
module lab7_pio_pulse_timer
   import lab7_pio_pkg::*;
#(
   parameter int unsigned PLEN_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [PLEN_W-1:0] i_len,
   output logic [PLEN_W-1:0] o_count,
   output logic              o_active
);

   pulse_state_t      r_state;
   pulse_state_t      w_state_nxt;
   logic [PLEN_W-1:0] r_count;
   logic [PLEN_W-1:0] w_count_nxt;
   logic [PLEN_W-1:0] w_load;

   // A zero length still produces a one-cycle pulse
   assign w_load = (i_len == '0) ? PLEN_W'(1) : i_len;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= P_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   // Restart has priority over both abort and same-edge expiry
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      case (r_state)
         P_IDLE: begin
            if (i_start) begin
               w_state_nxt = P_ACTIVE;
               w_count_nxt = w_load;
            end
         end
         P_ACTIVE: begin
            if (i_start) begin
               w_count_nxt = w_load;
            end else if (i_abort || (r_count == PLEN_W'(1))) begin
               w_state_nxt = P_IDLE;
               w_count_nxt = '0;
            end else begin
               w_count_nxt = r_count - PLEN_W'(1);
            end
         end
         default: begin
            w_state_nxt = P_IDLE;
            w_count_nxt = '0;
         end
      endcase
   end

   assign o_count  = r_count;
   assign o_active = (r_state == P_ACTIVE);

endmodule

// File: rtl/lab7_soc_leds_pio.sv
// Avalon-MM output PIO for the board LEDs: data register, atomic set/clear and a timed blink mask.
module lab7_soc_leds_pio
   import lab7_pio_pkg::*;
#(
   parameter int unsigned        WIDTH       = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter int unsigned        PLEN_W      = 16,
   parameter int unsigned        PLEN_RESET  = 1000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [BUS_W-1:0]  writedata,
   output logic [BUS_W-1:0]  readdata,
   output logic [WIDTH-1:0]  out_port
);

   logic [WIDTH-1:0]  r_data;
   logic [WIDTH-1:0]  r_mask;
   logic [PLEN_W-1:0] r_len;
   logic [WIDTH-1:0]  w_data_nxt;
   logic [WIDTH-1:0]  w_wd;
   logic [WIDTH-1:0]  w_mask;
   logic [PLEN_W-1:0] w_count;
   logic [BUS_W-1:0]  w_rd;
   logic              w_active;
   logic              w_wr;
   logic              w_wr_pulse;
   logic              w_unused_wd;

   assign w_wd        = writedata[WIDTH-1:0];
   assign w_unused_wd = ^writedata;
   assign w_wr        = chipselect && !write_n;
   assign w_wr_pulse  = w_wr && (address == ADDR_PULSE);

   lab7_pio_pulse_timer #(
      .PLEN_W (PLEN_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_start  (w_wr_pulse && (w_wd != '0)),
      .i_abort  (w_wr_pulse && (w_wd == '0)),
      .i_len    (r_len),
      .o_count  (w_count),
      .o_active (w_active)
   );

   // Mask only counts while the timer runs, so expiry needs no extra clear path
   assign w_mask   = w_active ? r_mask : '0;
   assign out_port = r_data ^ w_mask;

   always_comb begin
      w_data_nxt = r_data;
      if (w_wr) begin
         case (address)
            ADDR_DATA:     w_data_nxt = w_wd;
            ADDR_OUTSET:   w_data_nxt = r_data | w_wd;
            ADDR_OUTCLEAR: w_data_nxt = r_data & ~w_wd;
            default:       w_data_nxt = r_data;
         endcase
      end
   end

   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA:  w_rd = BUS_W'(r_data);
         ADDR_PULSE: w_rd = BUS_W'(w_mask);
         ADDR_PLEN:  w_rd = BUS_W'(r_len);
         ADDR_COUNT: w_rd = BUS_W'(w_count);
         default:    w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data   <= RESET_VALUE;
         r_mask   <= '0;
         r_len    <= PLEN_W'(PLEN_RESET);
         readdata <= '0;
      end else begin
         r_data   <= w_data_nxt;
         readdata <= w_rd;
         if (w_wr_pulse) begin
            r_mask <= w_wd;
         end
         if (w_wr && (address == ADDR_PLEN)) begin
            r_len <= writedata[PLEN_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_lab7_soc_leds_pio.sv
// Scoreboard bench for lab7_soc_leds_pio: each bus cycle queues expected readdata/out_port.
module tb_lab7_soc_leds_pio;

   bit          clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;

   typedef struct {
      string       nm;
      logic [31:0] rd;
      logic [7:0]  port;
   } exp_t;

   exp_t q[$];
   bit   rd_req;
   bit   rd_valid;
   int   total;
   int   bad;
   bit   done;

   lab7_soc_leds_pio #(
      .WIDTH       (8),
      .RESET_VALUE (8'h00),
      .PLEN_W      (16),
      .PLEN_RESET  (1000)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endfunction

   // Monitor: a request issued before an edge is checked at the following negedge
   always @(posedge clk) rd_valid <= rd_req;

   always @(negedge clk) begin
      if (rd_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL monitor: output cycle with empty scoreboard");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, ".rd"}, readdata, e.rd);
            chk({e.nm, ".port"}, 32'(out_port), 32'(e.port));
         end
      end
   end

   task automatic cyc(input logic [2:0] a, input bit cs, input bit wr, input logic [31:0] wd,
                      input logic [31:0] erd, input logic [7:0] eport, input string nm);
      exp_t e;
      address    = a;
      chipselect = cs;
      write_n    = !wr;
      writedata  = wd;
      e.nm = nm; e.rd = erd; e.port = eport;
      q.push_back(e);
      rd_req = 1'b1;
      @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd,
                     input logic [31:0] erd, input logic [7:0] eport, input string nm);
      cyc(a, 1'b1, 1'b1, wd, erd, eport, nm);
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] erd, input logic [7:0] eport,
                     input string nm);
      cyc(a, 1'b1, 1'b0, 32'h0, erd, eport, nm);
   endtask

   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout: bench did not complete");
         bad++;
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin
      reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      rd_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_port", 32'(out_port), 32'h00);
      chk("reset_rd", readdata, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);

      rd(3'd2, 32'd1000, 8'h00, "plen_reset");
      wr(3'd0, 32'hA5, 32'h0, 8'hA5, "wr_data");
      rd(3'd0, 32'hA5, 8'hA5, "rd_data");
      wr(3'd4, 32'h0F, 32'h0, 8'hAF, "outset");
      wr(3'd5, 32'hA0, 32'h0, 8'h0F, "outclear");
      cyc(3'd0, 1'b0, 1'b1, 32'hFF, 32'h0F, 8'h0F, "cs0_ignored");
      rd(3'd0, 32'h0F, 8'h0F, "cs0_data");
      wr(3'd6, 32'hFF, 32'h0, 8'h0F, "rsvd6_wr");
      rd(3'd7, 32'h0, 8'h0F, "rsvd7_rd");

      // Three-cycle pulse on bit 0
      wr(3'd2, 32'd3, 32'd1000, 8'h0F, "plen3");
      wr(3'd1, 32'h01, 32'h0, 8'h0E, "pulse_start");
      rd(3'd3, 32'd3, 8'h0E, "count3");
      rd(3'd3, 32'd2, 8'h0E, "count2");
      rd(3'd3, 32'd1, 8'h0F, "count1_expire");
      rd(3'd3, 32'd0, 8'h0F, "count0");
      rd(3'd1, 32'h0, 8'h0F, "mask_idle");

      // Zero length behaves as one cycle
      wr(3'd2, 32'd0, 32'd3, 8'h0F, "plen0");
      wr(3'd1, 32'h80, 32'h0, 8'h8F, "pulse_len0");
      rd(3'd1, 32'h80, 8'h0F, "mask_live");
      rd(3'd3, 32'd0, 8'h0F, "len0_done");

      // Restart mid-pulse reloads the full length
      wr(3'd2, 32'd5, 32'd0, 8'h0F, "plen5");
      wr(3'd1, 32'h01, 32'h0, 8'h0E, "p5_start");
      rd(3'd3, 32'd5, 8'h0E, "p5_c5");
      rd(3'd3, 32'd4, 8'h0E, "p5_c4");
      wr(3'd1, 32'h02, 32'h01, 8'h0D, "restart");
      rd(3'd3, 32'd5, 8'h0D, "rs_c5");
      rd(3'd3, 32'd4, 8'h0D, "rs_c4");
      rd(3'd3, 32'd3, 8'h0D, "rs_c3");
      rd(3'd3, 32'd2, 8'h0D, "rs_c2");
      rd(3'd3, 32'd1, 8'h0F, "rs_expire");

      // Restart on the expiry edge wins
      wr(3'd2, 32'd1, 32'd5, 8'h0F, "plen1");
      wr(3'd1, 32'h01, 32'h0, 8'h0E, "p1_start");
      wr(3'd1, 32'h04, 32'h01, 8'h0B, "restart_at_expiry");
      rd(3'd3, 32'd1, 8'h0F, "p1_expire");

      // Abort, with a DATA write during the pulse
      wr(3'd2, 32'd5, 32'd1, 8'h0F, "plen5b");
      wr(3'd1, 32'h01, 32'h0, 8'h0E, "ab_start");
      wr(3'd0, 32'h30, 32'h0F, 8'h31, "data_mid_pulse");
      wr(3'd1, 32'h00, 32'h01, 8'h30, "abort");
      rd(3'd3, 32'd0, 8'h30, "abort_count");

      // Reset mid-pulse at count 2
      wr(3'd1, 32'h01, 32'h0, 8'h31, "rst_start");
      rd(3'd3, 32'd5, 8'h31, "rst_c5");
      rd(3'd3, 32'd4, 8'h31, "rst_c4");
      rd(3'd3, 32'd3, 8'h31, "rst_c3");
      rd_req = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_port", 32'(out_port), 32'h00);
      chk("async_rst_rd", readdata, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rd(3'd3, 32'd0, 8'h00, "post_rst_count");
      rd(3'd0, 32'h0, 8'h00, "post_rst_data");
      rd(3'd2, 32'd1000, 8'h00, "post_rst_plen");

      rd_req = 1'b0;
      chipselect = 1'b0;
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
